// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares the FIFO RAM write ports among requesters with rotating priority and starvation override
module fifo_wr_arbiter #(
  parameter int N_REQ = 4,
  parameter int N_WRITE_PORTS = 2,
  parameter int ENTRY_WIDTH = 32,
  parameter int N_ENTRIES = 8,
  parameter int STARVE_LIMIT = 7,
  localparam int PTR_WIDTH = $clog2(N_ENTRIES),
  localparam int RW = $clog2(N_REQ),
  localparam int CW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic clk,
  input  logic rst_aL,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] req_ready,
  input  logic [N_REQ-1:0][PTR_WIDTH-1:0] req_addr,
  input  logic [N_REQ-1:0][ENTRY_WIDTH-1:0] req_data,
  input  logic enq_fire,
  input  logic [PTR_WIDTH-1:0] enq_ptr,
  output logic [N_WRITE_PORTS-1:0] wr_en,
  output logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0] wr_addr,
  output logic [N_WRITE_PORTS-1:0][ENTRY_WIDTH-1:0] wr_data,
  output logic [RW-1:0] rr_ptr
);
  logic [CW-1:0] wait_ctr [N_REQ];
  logic [N_REQ-1:0] blocked, starved, ready_c;
  logic [N_WRITE_PORTS-1:0] en_c;
  logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0] addr_c;
  logic [N_WRITE_PORTS-1:0][ENTRY_WIDTH-1:0] data_c;
  logic [RW-1:0] idx, last;
  logic hit;
  int cnt;
  // per-requester enqueue-collision and starvation flags
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      blocked[i] = enq_fire && (req_addr[i] == enq_ptr);
      starved[i] = wait_ctr[i] == CW'(STARVE_LIMIT);
    end
  end
  // two rotating scans (starved first, then the rest) filling write ports in grant order
  always_comb begin
    ready_c = '0;
    en_c = '0;
    addr_c = '0;
    data_c = '0;
    cnt = 0;
    last = rr_ptr;
    idx = '0;
    hit = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int j = 0; j < N_REQ; j++) begin
        idx = rr_ptr + RW'(j);
        hit = 1'b0;
        for (int k = 0; k < N_WRITE_PORTS; k++)
          if (k < cnt && addr_c[k] == req_addr[idx]) hit = 1'b1;
        if (req_valid[idx] && !blocked[idx] && (starved[idx] == (p == 0)) && cnt < N_WRITE_PORTS && !hit) begin
          ready_c[idx] = 1'b1;
          last = idx;
          for (int k = 0; k < N_WRITE_PORTS; k++) begin
            if (k == cnt) begin
              en_c[k] = 1'b1;
              addr_c[k] = req_addr[idx];
              data_c[k] = req_data[idx];
            end
          end
          cnt = cnt + 1;
        end
      end
    end
  end
  assign req_ready = rst_aL ? ready_c : '0;
  assign wr_en = rst_aL ? en_c : '0;
  assign wr_addr = rst_aL ? addr_c : '0;
  assign wr_data = rst_aL ? data_c : '0;
  // priority head moves past the last grant; wait counters track ungranted valid cycles
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      rr_ptr <= '0;
      for (int i = 0; i < N_REQ; i++) wait_ctr[i] <= '0;
    end else begin
      if (|ready_c) rr_ptr <= last + RW'(1);
      for (int i = 0; i < N_REQ; i++)
        wait_ctr[i] <= (!req_valid[i] || ready_c[i]) ? '0 : starved[i] ? wait_ctr[i] : wait_ctr[i] + CW'(1);
    end
  end
endmodule
